spi_ram: RTL and testbench

- SPI slave front-end combined with a 256x8 single-port synchronous RAM.
- A master shifts 10-bit frames in on MOSI while SS_n is low. Each frame carries a 2-bit command and an 8-bit payload.
- Commands: write address, write data, read address, read data. For a read-data frame, the RAM byte is shifted back out on MISO.
- Leaf peripheral, clocked by the system clock; the SPI clock is not separate.

---
 rtl/spi_ram_pkg.sv | 33 +++
 rtl/spi_ram_if.sv | 21 ++
 rtl/spi_ram_mem.sv | 65 ++++++
 rtl/spi_ram_slave.sv | 125 ++++++++++++
 rtl/spi_ram.sv | 42 ++++
 tb/tb_spi_ram.sv | 188 ++++++++++++++++++
 6 files changed

// File: rtl/spi_ram_pkg.sv
// -----------------------------------------------------------------------------
// spi_ram_pkg
// Shared types and constants for the SPI-fronted RAM:
//   state_e  - slave FSM states
//   cmd_t    - 2-bit frame command and its four encodings
//   FRAME_W  - serial frame width {cmd[1:0], payload[7:0]}
// -----------------------------------------------------------------------------
package spi_ram_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_WR_ADDR = 2'b00;
    localparam cmd_t CMD_WR_DATA = 2'b01;
    localparam cmd_t CMD_RD_ADDR = 2'b10;
    localparam cmd_t CMD_RD_DATA = 2'b11;

    // Command field of a received frame.
    function automatic cmd_t frame_cmd(input logic [FRAME_W-1:0] frame);
        return frame[FRAME_W-1 -: 2];
    endfunction

endpackage

// File: rtl/spi_ram_if.sv
// -----------------------------------------------------------------------------
// spi_ram_if
// Internal bus between the SPI slave and the RAM.
//   rx_data  - full received frame {cmd, payload}, valid while rx_valid=1
//   rx_valid - one-cycle pulse per completed frame
//   tx_data  - RAM read byte, valid while tx_valid=1
//   tx_valid - one-cycle pulse answering a read-data frame
// Modports: master = SPI slave side, slave = RAM side.
// -----------------------------------------------------------------------------
interface spi_ram_if;
    import spi_ram_pkg::*;

    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;

    modport master (output rx_data, rx_valid, input  tx_data, tx_valid);
    modport slave  (input  rx_data, rx_valid, output tx_data, tx_valid);

endinterface

// File: rtl/spi_ram_mem.sv
// -----------------------------------------------------------------------------
// spi_ram_mem
// Single-port synchronous RAM decoding frames from the SPI slave.
// Ports:
//   clk, rst_n - system clock, synchronous active-low reset
//   bus_s      - frame in (rx_*), read byte out one cycle later (tx_*)
// Storage mem[0:MEM_DEPTH-1] is addressable hierarchically for preloading.
// ADDR_SIZE must not exceed the 8-bit payload width.
// -----------------------------------------------------------------------------
module spi_ram_mem
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    spi_ram_if.slave  bus_s
);

    logic [DATA_W-1:0]    mem [0:MEM_DEPTH-1];
    logic [ADDR_SIZE-1:0] wr_addr_q;
    logic [ADDR_SIZE-1:0] rd_addr_q;
    logic [DATA_W-1:0]    dout_q;
    logic                 tx_valid_q;

    cmd_t              cmd;
    logic [DATA_W-1:0] payload;

    assign cmd     = frame_cmd(bus_s.rx_data);
    assign payload = bus_s.rx_data[DATA_W-1:0];

    // NOTE: the storage array has no reset so it maps onto a RAM macro; only
    // the write enable sees rst_n, so a frame landing on a reset edge is lost.
    always_ff @(posedge clk) begin
        if (rst_n && bus_s.rx_valid && cmd == CMD_WR_DATA)
            mem[wr_addr_q] <= payload;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            tx_valid_q <= 1'b0;
            if (bus_s.rx_valid) begin
                case (cmd)
                    CMD_WR_ADDR: wr_addr_q <= payload[ADDR_SIZE-1:0];
                    CMD_RD_ADDR: rd_addr_q <= payload[ADDR_SIZE-1:0];
                    CMD_RD_DATA: begin
                        dout_q     <= mem[rd_addr_q];
                        tx_valid_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus_s.tx_data  = dout_q;
    assign bus_s.tx_valid = tx_valid_q;

endmodule

// File: rtl/spi_ram_slave.sv
// -----------------------------------------------------------------------------
// spi_ram_slave
// SPI slave: command FSM, 10-bit MOSI deserializer, 8-bit MISO serializer.
// Ports:
//   clk, rst_n - system clock, synchronous active-low reset
//   mosi_i     - serial data in, sampled on rising clk
//   ss_n_i     - active-low select; high aborts and returns to IDLE
//   miso_o     - serial read data out, 0 when not transmitting
//   bus_m      - frame/read-byte handshake to the RAM
// -----------------------------------------------------------------------------
module spi_ram_slave
    import spi_ram_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mosi_i,
    input  logic        ss_n_i,
    output logic        miso_o,
    spi_ram_if.master   bus_m
);

    localparam logic [3:0] FRAME_CNT = 4'(FRAME_W);

    state_e             state_q;
    logic [FRAME_W-1:0] shift_q;
    logic [3:0]         bit_cnt_q;
    logic               rd_addr_seen_q;
    logic               rx_valid_q;
    logic [FRAME_W-1:0] rx_data_q;
    logic [DATA_W-1:0]  tx_shift_q;
    logic [3:0]         tx_cnt_q;
    logic               miso_q;

    // Frame including the bit being sampled this cycle.
    logic [FRAME_W-1:0] frame_d;
    cmd_t               cmd_d;

    assign frame_d = {shift_q[FRAME_W-2:0], mosi_i};

    // The state chosen in CHK_CMD decides the command class, so a read-data
    // frame sent before any read address is forwarded as a read address.
    // NOTE: every output of an always_comb gets a default first so no latch
    // can be inferred when a branch forgets to assign it.
    always_comb begin
        cmd_d = {1'b0, frame_d[FRAME_W-2]};
        case (state_q)
            READ_ADD:  cmd_d = CMD_RD_ADDR;
            READ_DATA: cmd_d = CMD_RD_DATA;
            default:   ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            rd_addr_seen_q <= 1'b0;
            rx_valid_q     <= 1'b0;
            rx_data_q      <= '0;
            tx_shift_q     <= '0;
            tx_cnt_q       <= '0;
            miso_q         <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (ss_n_i) begin
                // Deselect discards any partial frame or pending read-out.
                state_q   <= IDLE;
                shift_q   <= '0;
                bit_cnt_q <= '0;
                tx_cnt_q  <= '0;
                miso_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: state_q <= CHK_CMD;
                    CHK_CMD: begin
                        bit_cnt_q <= '0;
                        if (!mosi_i)
                            state_q <= WRITE;
                        else if (rd_addr_seen_q)
                            state_q <= READ_DATA;
                        else
                            state_q <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        // Bits past the tenth are ignored until deselect.
                        if (bit_cnt_q < FRAME_CNT) begin
                            shift_q   <= frame_d;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == FRAME_CNT - 4'd1) begin
                                rx_valid_q <= 1'b1;
                                rx_data_q  <= {cmd_d, frame_d[DATA_W-1:0]};
                                if (state_q == READ_ADD)
                                    rd_addr_seen_q <= 1'b1;
                                else if (state_q == READ_DATA)
                                    rd_addr_seen_q <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase

                // MISO: MSB on the edge the RAM byte arrives, then 7 more bits.
                if (bus_m.tx_valid && state_q == READ_DATA) begin
                    miso_q     <= bus_m.tx_data[DATA_W-1];
                    tx_shift_q <= {bus_m.tx_data[DATA_W-2:0], 1'b0};
                    tx_cnt_q   <= 4'(DATA_W - 1);
                end else if (tx_cnt_q != '0) begin
                    miso_q     <= tx_shift_q[DATA_W-1];
                    tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
                    tx_cnt_q   <= tx_cnt_q - 4'd1;
                end else begin
                    miso_q <= 1'b0;
                end
            end
        end
    end

    assign miso_o         = miso_q;
    assign bus_m.rx_valid = rx_valid_q;
    assign bus_m.rx_data  = rx_data_q;

endmodule

// File: rtl/spi_ram.sv
// -----------------------------------------------------------------------------
// spi_ram
// SPI slave front-end with a 256x8 single-port RAM behind it.
// Ports:
//   MOSI  - serial frame data from master, {cmd[1:0], payload[7:0]} MSB first
//   MISO  - serial read data to master, 0 when idle
//   SS_n  - active-low slave select
//   clk   - system clock, all logic on the rising edge
//   rst_n - synchronous active-low reset
// -----------------------------------------------------------------------------
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic MOSI,
    output logic MISO,
    input  logic SS_n,
    input  logic clk,
    input  logic rst_n
);

    spi_ram_if bus_if ();

    spi_ram_slave u_slave (
        .clk    (clk),
        .rst_n  (rst_n),
        .mosi_i (MOSI),
        .ss_n_i (SS_n),
        .miso_o (MISO),
        .bus_m  (bus_if)
    );

    spi_ram_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) DUT_RAM (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_s  (bus_if)
    );

endmodule

// File: tb/tb_spi_ram.sv
// -----------------------------------------------------------------------------
// tb_spi_ram
// Transaction-level model of the SPI RAM (address registers, read-address
// flag, byte array) predicts MISO for every clock; one process compares it.
// Directed frames pin the model to hand-computed bytes, then random frames.
// -----------------------------------------------------------------------------
module tb_spi_ram;
    import spi_ram_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic MOSI;
    logic SS_n;
    logic MISO;

    always #5 clk = ~clk;

    spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .MOSI  (MOSI),
        .MISO  (MISO),
        .SS_n  (SS_n),
        .clk   (clk),
        .rst_n (rst_n)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_miso = 1'b0;
    bit   cmp_en   = 1'b0;

    // Behavioural model state
    logic [7:0] mem_m [256];
    logic [7:0] wa_m;
    logic [7:0] ra_m;
    bit         seen_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en)
            check("miso", 32'(MISO), 32'(exp_miso));
    end

    // One clock: drive inputs mid-cycle, state what MISO must be after the edge.
    task automatic cyc(input logic rst, input logic ss, input logic mosi,
                       input logic e, output logic obs);
        @(negedge clk);
        rst_n = rst;
        SS_n  = ss;
        MOSI  = mosi;
        @(posedge clk);
        #1;
        exp_miso = e;
        obs      = MISO;
    endtask

    function automatic void model_reset();
        wa_m   = 8'h00;
        ra_m   = 8'h00;
        seen_m = 1'b0;
    endfunction

    // Full transaction: IDLE cycle, command-check bit, abort_at frame bits
    // (>= 10 means the frame completes), read-out if any, extra idle-low
    // cycles, then deselect. got returns the 8 MISO bits observed.
    task automatic xfer(input logic chk, input logic [9:0] frame, input int abort_at,
                        input int extra, output logic [7:0] got);
        logic       o;
        cmd_t       kind;
        logic [7:0] pl;
        logic [7:0] byte_e;
        got    = 8'h00;
        byte_e = 8'h00;
        pl     = frame[7:0];
        if (chk)
            kind = seen_m ? CMD_RD_DATA : CMD_RD_ADDR;
        else
            kind = frame[8] ? CMD_WR_DATA : CMD_WR_ADDR;
        cyc(1'b1, 1'b0, 1'($urandom), 1'b0, o);
        cyc(1'b1, 1'b0, chk, 1'b0, o);
        for (int i = 0; i < FRAME_W && i < abort_at; i++)
            cyc(1'b1, 1'b0, frame[9-i], 1'b0, o);
        if (abort_at >= FRAME_W) begin
            case (kind)
                CMD_WR_ADDR: wa_m = pl;
                CMD_WR_DATA: mem_m[wa_m] = pl;
                CMD_RD_ADDR: begin ra_m = pl; seen_m = 1'b1; end
                default:     begin byte_e = mem_m[ra_m]; seen_m = 1'b0; end
            endcase
            if (kind == CMD_RD_DATA) begin
                cyc(1'b1, 1'b0, 1'($urandom), 1'b0, o);
                for (int i = 7; i >= 0; i--) begin
                    cyc(1'b1, 1'b0, 1'($urandom), byte_e[i], o);
                    got[i] = o;
                end
            end
            for (int i = 0; i < extra; i++)
                cyc(1'b1, 1'b0, 1'($urandom), 1'b0, o);
        end
        cyc(1'b1, 1'b1, 1'($urandom), 1'b0, o);
    endtask

    initial begin
        logic       o;
        logic [7:0] got;
        logic       chk;
        logic [9:0] fr;
        int         ab;

        rst_n = 1'b0;
        SS_n  = 1'b1;
        MOSI  = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, o);
        cmp_en = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, o);
        model_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, o);

        // Fill the RAM with known contents; 0x87 stays zero.
        for (int a = 0; a < 256; a++) begin
            xfer(1'b0, {CMD_WR_ADDR, 8'(a)}, FRAME_W, 0, got);
            xfer(1'b0, {CMD_WR_DATA, (a == 8'h87) ? 8'h00 : 8'($urandom)}, FRAME_W, 0, got);
        end

        // Directed frames with hand-computed results.
        xfer(1'b0, {CMD_WR_ADDR, 8'hD5}, FRAME_W, 0, got);
        xfer(1'b0, {CMD_WR_DATA, 8'h95}, FRAME_W, 2, got);
        check("model_mem_d5", 32'(mem_m[8'hD5]), 32'h95);
        xfer(1'b1, {CMD_RD_ADDR, 8'h87}, FRAME_W, 0, got);
        xfer(1'b1, {CMD_RD_DATA, 8'h00}, FRAME_W, 0, got);
        check("read_87", 32'(got), 32'h00);
        xfer(1'b1, {CMD_RD_ADDR, 8'hD5}, FRAME_W, 0, got);
        xfer(1'b1, {CMD_RD_DATA, 8'h00}, FRAME_W, 3, got);
        check("read_d5", 32'(got), 32'h95);

        // Write-data frame aborted after 5 bits must not touch mem[0xD5].
        xfer(1'b0, {CMD_WR_DATA, 8'h3C}, 5, 0, got);
        xfer(1'b1, {CMD_RD_ADDR, 8'hD5}, FRAME_W, 0, got);
        xfer(1'b1, {CMD_RD_DATA, 8'h00}, FRAME_W, 0, got);
        check("read_after_abort", 32'(got), 32'h95);

        // Read-data frame without a preceding read address acts as one.
        xfer(1'b1, {CMD_RD_DATA, 8'h87}, FRAME_W, 0, got);
        check("model_seen_set", 32'(seen_m), 32'h1);
        xfer(1'b1, {CMD_RD_DATA, 8'h00}, FRAME_W, 0, got);
        check("read_87_implicit", 32'(got), 32'h00);

        // Reset in the middle of a write-data frame: no write, registers cleared.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, o);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, o);
        fr = {CMD_WR_DATA, 8'h00};
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 1'b0, fr[9-i], 1'b0, o);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, o);
        model_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, o);
        xfer(1'b1, {CMD_RD_DATA, 8'hD5}, FRAME_W, 0, got);
        xfer(1'b1, {CMD_RD_DATA, 8'h00}, FRAME_W, 0, got);
        check("read_after_reset", 32'(got), 32'h95);
        // Write address was reset to 0, so this lands in mem[0].
        xfer(1'b0, {CMD_WR_DATA, 8'hA6}, FRAME_W, 0, got);
        xfer(1'b1, {CMD_RD_ADDR, 8'h00}, FRAME_W, 0, got);
        xfer(1'b1, {CMD_RD_DATA, 8'h00}, FRAME_W, 0, got);
        check("read_mem0", 32'(got), 32'hA6);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            chk = 1'($urandom);
            if (chk)
                fr = {seen_m ? CMD_RD_DATA : CMD_RD_ADDR, 8'($urandom)};
            else
                fr = {1'b0, 1'($urandom), 8'($urandom)};
            ab = ($urandom_range(7, 0) == 0) ? int'($urandom_range(9, 0)) : FRAME_W;
            xfer(chk, fr, ab, int'($urandom_range(3, 0)), got);
        end

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
